// File: rtl/multicycle_core_if.sv
// Instruction-fetch and shared-DRAM bus of one multicycle core.
// The core drives the master side; IRAM and the DRAM arbiter sit on the slave side.
interface multicycle_core_if #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DRAM_AW = 8
);
    logic [PC_W-1:0]    iram_addr;
    logic [15:0]        iram_in;
    logic               dram_req;
    logic               dram_we;
    logic [DRAM_AW-1:0] dram_addr;
    logic [DATA_W-1:0]  dram_out;
    logic [DATA_W-1:0]  dram_in;
    logic               dram_ack;

    modport master (
        output iram_addr, dram_req, dram_we, dram_addr, dram_out,
        input  iram_in, dram_in, dram_ack
    );

    modport slave (
        input  iram_addr, dram_req, dram_we, dram_addr, dram_out,
        output iram_in, dram_in, dram_ack
    );
endinterface

// File: rtl/multicycle_core.sv
// Self-sequenced core: FETCH/DECODE/EXEC(/MEM) gives 3 cycles per op, 4+wait for loads/stores held until dram_ack.
// MULTICYCLE_CORE_PERF_EN adds saturating retired_cnt/stall_cnt outputs; the default build has neither.
module multicycle_core #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DRAM_AW = 8
) (
    input  logic              clock,
    input  logic              reset,
    multicycle_core_if.master bus,
    output logic [PC_W-1:0]   pc_out,
    output logic [15:0]       ir_out,
    output logic [1:0]        flags_out,
    output logic              halted,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_reg
`ifdef MULTICYCLE_CORE_PERF_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SHL, OP_SHR, OP_JMP, OP_JZ, OP_JC, OP_MOV, OP_HALT
    } op_t;

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [15:0]         ir_q;
    logic [DATA_W-1:0]   rf_q [4];
    logic [1:0]          flags_q;     // {C, Z}
    logic                halted_q;
    logic                dram_req_q;
    logic                dram_we_q;
    logic [DRAM_AW-1:0]  dram_addr_q;
    logic [DATA_W-1:0]   dram_out_q;

    op_t                 op;
    logic [1:0]          rd;
    logic [1:0]          rs;
    logic [7:0]          imm;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W:0]     alu_d;       // {carry, result}
    logic                jump_d;

    assign op  = op_t'(ir_q[15:12]);
    assign rd  = ir_q[11:10];
    assign rs  = ir_q[9:8];
    assign imm = ir_q[7:0];
    assign opa = rf_q[rd];
    assign opb = rf_q[rs];

    // Top bit of the widened result is carry (ADD), borrow (SUB) or the bit shifted out.
    always_comb begin
        alu_d = '0;
        case (op)
            OP_ADD:  alu_d = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  alu_d = {1'b0, opa} - {1'b0, opb};
            OP_AND:  alu_d = {1'b0, opa & opb};
            OP_OR:   alu_d = {1'b0, opa | opb};
            OP_XOR:  alu_d = {1'b0, opa ^ opb};
            OP_SHL:  alu_d = {opa, 1'b0};
            OP_SHR:  alu_d = {opa[0], 1'b0, opa[DATA_W-1:1]};
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        jump_d = 1'b0;
        case (op)
            OP_JMP:  jump_d = 1'b1;
            OP_JZ:   jump_d = flags_q[0];
            OP_JC:   jump_d = flags_q[1];
            default: jump_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            flags_q     <= '0;
            halted_q    <= 1'b0;
            dram_req_q  <= 1'b0;
            dram_we_q   <= 1'b0;
            dram_addr_q <= '0;
            dram_out_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q    <= bus.iram_in;
                    pc_q    <= pc_q + PC_W'(1);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    case (op)
                        OP_LDI: rf_q[rd] <= DATA_W'(imm);
                        OP_LOAD, OP_STORE: begin
                            dram_req_q  <= 1'b1;
                            dram_we_q   <= (op == OP_STORE);
                            dram_addr_q <= DRAM_AW'(imm);
                            dram_out_q  <= opa;
                            state_q     <= S_MEM;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                            rf_q[rd] <= alu_d[DATA_W-1:0];
                            flags_q  <= {alu_d[DATA_W], alu_d[DATA_W-1:0] == '0};
                        end
                        OP_JMP, OP_JZ, OP_JC: begin
                            if (jump_d) pc_q <= PC_W'(imm);
                        end
                        OP_MOV: rf_q[rd] <= opb;
                        OP_HALT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (bus.dram_ack) begin
                        if (!dram_we_q) rf_q[rd] <= bus.dram_in;
                        dram_req_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_CORE_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;
    logic        retire_d;

    assign retire_d = ((state_q == S_EXEC) && !(op inside {OP_LOAD, OP_STORE, OP_HALT}))
                   || ((state_q == S_MEM) && bus.dram_ack);

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire_d && (retired_q != '1)) retired_q <= retired_q + 32'd1;
            if ((state_q == S_MEM) && !bus.dram_ack && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

    assign bus.iram_addr = pc_q;
    assign bus.dram_req  = dram_req_q;
    assign bus.dram_we   = dram_we_q;
    assign bus.dram_addr = dram_addr_q;
    assign bus.dram_out  = dram_out_q;
    assign pc_out        = pc_q;
    assign ir_out        = ir_q;
    assign flags_out     = flags_q;
    assign halted        = halted_q;
    assign dbg_reg       = rf_q[dbg_sel];

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: an ISA-level model queues per-instruction expectations,
// a monitor pops them at each instruction boundary; also covers reset during a pending memory access.
module tb_multicycle_core;
    localparam int DW = 16;
    localparam int PW = 8;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] pc_out;
    logic [15:0]   ir_out;
    logic [1:0]    flags_out;
    logic          halted;
    logic [1:0]    dbg_sel;
    logic [DW-1:0] dbg_reg;
`ifdef MULTICYCLE_CORE_PERF_EN
    logic [31:0]   retired_cnt;
    logic [31:0]   stall_cnt;
`endif

    multicycle_core_if #(.DATA_W(DW), .PC_W(PW), .DRAM_AW(AW)) bus ();

    multicycle_core #(.DATA_W(DW), .PC_W(PW), .DRAM_AW(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .pc_out(pc_out),
        .ir_out(ir_out),
        .flags_out(flags_out),
        .halted(halted),
        .dbg_sel(dbg_sel),
        .dbg_reg(dbg_reg)
`ifdef MULTICYCLE_CORE_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic               is_mem;
        logic               is_halt;
        logic               we;
        logic [7:0]         maddr;
        logic [DW-1:0]      mdata;
        logic [7:0]         mem_cycles;
        logic [7:0]         pc;
        logic [3:0][DW-1:0] r;
        logic [1:0]         flags;
    } exp_t;

    exp_t          exp_q[$];
    int            dly_q[$];
    int            tests = 0;
    int            fails = 0;

    logic [15:0]   iram [256];
    logic [DW-1:0] dmem [256];
    logic [DW-1:0] mdl_dram [256];

    int            m_pc;
    logic [DW-1:0] m_r [4];
    bit            m_c, m_z;

    logic          resp_en, resp_ack, man_ack;
    logic [DW-1:0] resp_din, man_din;
    assign bus.dram_ack = resp_ack | man_ack;
    assign bus.dram_in  = man_ack ? man_din : resp_din;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Synchronous IRAM: data for the address seen at an edge appears just after it.
    initial begin
        bus.iram_in = '0;
        forever begin
            @(posedge clock);
            #1 bus.iram_in = iram[bus.iram_addr];
        end
    end

    // DRAM responder: acks after the number of idle MEM cycles queued by the stimulus.
    initial begin
        int busy = 0;
        int left = 0;
        resp_ack = 1'b0;
        resp_din = '0;
        forever begin
            @(negedge clock);
            resp_ack = 1'b0;
            if (reset || !resp_en) busy = 0;
            else if (bus.dram_req) begin
                if (busy == 0) begin
                    busy = 1;
                    left = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                end
                if (left == 0) begin
                    resp_ack = 1'b1;
                    busy     = 0;
                    if (bus.dram_we) dmem[bus.dram_addr] = bus.dram_out;
                    else resp_din = dmem[bus.dram_addr];
                end else left--;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = 0;
        m_c  = 0;
        m_z  = 0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
    endtask

    // Architectural step: applies one instruction and queues the state the core must show afterwards.
    task automatic model_exec(input logic [15:0] ins, input int w);
        exp_t   e;
        int     op, rd, rs, imm;
        longint a, b, res, full;
        bit     c, alu;
        op   = int'(ins[15:12]);
        rd   = int'(ins[11:10]);
        rs   = int'(ins[9:8]);
        imm  = int'(ins[7:0]);
        a    = longint'(m_r[rd]);
        b    = longint'(m_r[rs]);
        full = longint'(1) << DW;
        res  = 0;
        c    = 0;
        alu  = (op >= 4 && op <= 10);
        e    = '0;
        m_pc = (m_pc + 1) % 256;
        case (op)
            1:  m_r[rd] = DW'(imm);
            2:  begin e.is_mem = 1; e.maddr = 8'(imm); e.mdata = m_r[rd]; m_r[rd] = mdl_dram[imm]; end
            3:  begin e.is_mem = 1; e.we = 1; e.maddr = 8'(imm); e.mdata = m_r[rd]; mdl_dram[imm] = m_r[rd]; end
            4:  begin res = a + b; c = (res >= full); res = res % full; end
            5:  begin c = (a < b); res = (a - b + full) % full; end
            6:  res = a & b;
            7:  res = a | b;
            8:  res = a ^ b;
            9:  begin c = (a >= full / 2); res = (a * 2) % full; end
            10: begin c = (a % 2 == 1); res = a / 2; end
            11: m_pc = imm;
            12: if (m_z) m_pc = imm;
            13: if (m_c) m_pc = imm;
            14: m_r[rd] = m_r[rs];
            15: e.is_halt = 1;
            default: ;
        endcase
        if (alu) begin
            m_r[rd] = DW'(res);
            m_z     = (res == 0);
            m_c     = c;
        end
        e.mem_cycles = 8'(w + 1);
        e.pc         = 8'(m_pc);
        for (int i = 0; i < 4; i++) e.r[i] = m_r[i];
        e.flags      = {m_c, m_z};
        exp_q.push_back(e);
        if (e.is_mem) dly_q.push_back(w);
    endtask

    task automatic step(input int addr, input logic [15:0] ins, input int w);
        iram[addr] = ins;
        model_exec(ins, w);
    endtask

    // Random straight-line program with short forward jumps, ending in HALT at 0xFF (pc then wraps to 0).
    task automatic build_random();
        int pc;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            iram[i]     = 16'h0000;
            dmem[i]     = DW'($urandom);
            mdl_dram[i] = dmem[i];
        end
        pc = 0;
        while (1) begin
            logic [15:0] ins;
            int          op;
            int          t;
            if (pc == 255) ins = 16'hF000;
            else begin
                op  = $urandom_range(0, 14);
                ins = 16'($urandom);
                ins[15:12] = 4'(op);
                if (op >= 11 && op <= 13) begin
                    t = pc + 1 + $urandom_range(0, 5);
                    if (t > 255) t = 255;
                    ins[7:0] = 8'(t);
                end
            end
            step(pc, ins, $urandom_range(0, 3));
            if (ins[15:12] == 4'hF) break;
            pc = m_pc;
        end
    endtask

    task automatic build_directed();
        model_reset();
        for (int i = 0; i < 256; i++) begin
            iram[i]     = 16'h0000;
            dmem[i]     = '0;
            mdl_dram[i] = '0;
        end
        dmem[8'h20]     = 16'hBEEF;
        mdl_dram[8'h20] = 16'hBEEF;
        step(8'h00, 16'hC050, 0);   // JZ 0x50, not taken first time
        step(8'h01, 16'h1005, 0);   // LDI R0,5
        step(8'h02, 16'h1403, 0);   // LDI R1,3
        step(8'h03, 16'h4100, 0);   // ADD R0,R1
        step(8'h04, 16'h18FF, 0);   // LDI R2,0xFF
        step(8'h05, 16'h1C01, 0);   // LDI R3,1
        for (int k = 0; k < DW; k++) step(8'h06 + k, 16'h9800, 0);
        step(8'h16, 16'hD040, 0);   // JC 0x40
        step(8'h40, 16'h3010, 5);   // STORE R0,0x10
        step(8'h41, 16'h2420, 0);   // LOAD R1,0x20
        step(8'h42, 16'h5500, 0);   // SUB R1,R1
        step(8'h43, 16'hB0FF, 0);   // JMP 0xFF
        step(8'hFF, 16'h0000, 0);   // NOP, pc wraps
        step(8'h00, 16'hC050, 0);   // JZ taken
        step(8'h50, 16'hF000, 0);   // HALT
    endtask

    task automatic check_regs(input string tag, input logic [3:0][DW-1:0] r);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s R%0d", tag, i), dbg_reg, r[i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rst pc"}, pc_out, 0);
        check({tag, " rst ir"}, ir_out, 0);
        check({tag, " rst flags"}, flags_out, 0);
        check({tag, " rst halted"}, halted, 0);
        check({tag, " rst req"}, bus.dram_req, 0);
        check({tag, " rst we"}, bus.dram_we, 0);
        check({tag, " rst addr"}, bus.dram_addr, 0);
        check({tag, " rst dout"}, bus.dram_out, 0);
`ifdef MULTICYCLE_CORE_PERF_EN
        check({tag, " rst retired"}, retired_cnt, 0);
        check({tag, " rst stall"}, stall_cnt, 0);
`endif
        check_regs({tag, " rst"}, '0);
    endtask

    // Starts at the falling edge of a FETCH cycle; every item ends at the falling edge of the next FETCH.
    task automatic monitor_run(input string tag);
        int k = 0;
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = $sformatf("%s#%0d", tag, k);
            repeat (3) @(posedge clock);
            @(negedge clock);
            if (e.is_mem) begin
                int cycles = 0;
                bit stable = 1;
`ifdef MULTICYCLE_CORE_PERF_EN
                logic [31:0] s0 = stall_cnt;
`endif
                check({n, " req"}, bus.dram_req, 1);
                check({n, " we"}, bus.dram_we, e.we);
                check({n, " addr"}, bus.dram_addr, e.maddr);
                check({n, " dout"}, bus.dram_out, e.mdata);
                while (bus.dram_req === 1'b1 && cycles < 400) begin
                    cycles++;
                    if (bus.dram_we !== e.we || bus.dram_addr !== e.maddr || bus.dram_out !== e.mdata)
                        stable = 0;
                    @(posedge clock);
                    @(negedge clock);
                end
                check({n, " mem cycles"}, cycles, e.mem_cycles);
                check({n, " mem stable"}, stable, 1);
`ifdef MULTICYCLE_CORE_PERF_EN
                check({n, " stall delta"}, stall_cnt - s0, e.mem_cycles - 1);
`endif
            end
            check({n, " pc"}, pc_out, e.pc);
            check({n, " flags"}, flags_out, e.flags);
            check({n, " halted"}, halted, e.is_halt);
            check_regs(n, e.r);
            if (e.is_halt) begin
                bit frozen = 1;
                repeat (20) begin
                    @(negedge clock);
                    if (pc_out !== e.pc || halted !== 1'b1) frozen = 0;
                end
                check({n, " halt frozen"}, frozen, 1);
            end
            k++;
        end
    endtask

    task automatic run_phase(input string tag);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_state(tag);
        fork
            reset = 1'b0;
            monitor_run(tag);
        join
    endtask

    task automatic reset_mid_mem();
        int  n;
        for (int i = 0; i < 256; i++) iram[i] = 16'h0000;
        iram[0] = 16'h1807;           // LDI R2,7
        iram[1] = 16'h2830;           // LOAD R2,0x30
        iram[2] = 16'hF000;
        resp_en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (bus.dram_req !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("midmem req seen", bus.dram_req, 1);
        repeat (2) @(negedge clock);
        dbg_sel = 2'd2;
        #1 check("midmem R2 before reset", dbg_reg, 7);
        // Reset and an ack land on the same edge: the reset must win.
        man_din = 16'hDEAD;
        man_ack = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        check_reset_state("midmem");
        reset = 1'b0;
        @(negedge clock);
        man_ack = 1'b0;
        check_regs("late ack", '0);
        check("late ack pc", pc_out, 0);
    endtask

    initial begin
        resp_en = 1'b1;
        man_ack = 1'b0;
        man_din = '0;
        dbg_sel = 2'd0;
        build_random();
        run_phase("rand");
        build_directed();
        run_phase("dir");
        reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Self-sequenced successor to the externally-controlled datapath: internal FSM replaces the 15-bit control word.
- Parametrised data width; 4-entry register file; Z/C flags.
- Registered PC fetches 16-bit instructions from synchronous IRAM; loads/stores go through a req/ack DRAM port, so N cores can share one arbitrated DRAM.
- One instance per core in the multicore top.

Parameters:
- DATA_W, 16, register/ALU/DRAM data width; legal 8..32.
- PC_W, 8, PC and IRAM address width; legal 8..16.
- DRAM_AW, 8, DRAM address width; legal 8..16.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- iram_addr  out  PC_W  equals pc_out, combinational from the PC register.
- iram_in  in  16  instruction, valid one cycle after iram_addr.
- dram_req  out  1  DRAM access request.
- dram_we  out  1  1 = store, 0 = load.
- dram_addr  out  DRAM_AW  access address.
- dram_out  out  DATA_W  store data.
- dram_in  in  DATA_W  load data, valid in the ack cycle.
- dram_ack  in  1  one-cycle completion/grant.
- pc_out  out  PC_W  program counter.
- ir_out  out  16  instruction register.
- flags_out  out  2  {C,Z}.
- halted  out  1  core is in HALT.
- dbg_sel  in  2  register-file read select.
- dbg_reg  out  DATA_W  combinational value of R[dbg_sel].

Behaviour:
- Reset (synchronous, active-high), applicable in any state including mid-MEM:
  - Next edge sets state=FETCH; pc, ir, R0..R3, flags, dram_req, dram_we, dram_addr, dram_out all =0; halted=0.
  - A pending ack is ignored.
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm. imm is zero-extended to DATA_W / PC_W / DRAM_AW as needed.
- FSM states: FETCH -> DECODE -> EXEC -> {FETCH | MEM | HALT}.
  - FETCH: iram_addr=pc; no register updates.
  - DECODE: ir<=iram_in; pc<=pc+1, mod 2^PC_W (wrap from all-ones to 0).
  - EXEC: executes op.
    - LOAD/STORE: registers dram_req=1, dram_we, dram_addr=imm, dram_out=R[rd]; goes to MEM.
    - HALT: goes to HALT.
    - All other ops: go to FETCH.
  - MEM: req/addr/we/data held stable until dram_ack=1 at a rising edge.
    - On that edge: LOAD writes R[rd]<=dram_in; dram_req<=0; state goes to FETCH.
    - ack while not in MEM is ignored.
    - Unbounded wait; no timeout.
  - HALT: absorbing; halted=1; only reset exits.
- Latency: non-memory op = 3 cycles; memory op = 4 + wait cycles (ack on the first MEM cycle gives 4).
- Opcodes:
  - 0 NOP.
  - 1 LDI: R[rd]=imm.
  - 2 LOAD: R[rd]=M[imm].
  - 3 STORE: M[imm]=R[rd].
  - 4 ADD: R[rd]+=R[rs]; C=carry out.
  - 5 SUB: R[rd]-=R[rs]; C=borrow.
  - 6 AND, 7 OR, 8 XOR: C=0.
  - 9 SHL: R[rd]<<=1; C=old MSB.
  - 10 SHR: logical shift right by 1; C=old LSB.
  - 11 JMP: pc=imm.
  - 12 JZ: jump if Z=1.
  - 13 JC: jump if C=1.
  - 14 MOV: R[rd]=R[rs].
  - 15 HALT.
- Flags:
  - Z=(result==0), updated only by ops 4-10.
  - LDI, LOAD and MOV leave flags unchanged.
- Arithmetic is modulo 2^DATA_W.
- rd==rs is legal: operands are read before write (e.g., SUB R1,R1 gives 0, Z=1, C=0).
- A jump overrides the DECODE increment. A taken jump to the current pc is a legal tight loop.

Optional Feature:
- Macro MULTICYCLE_CORE_PERF_EN.
- Defined: adds two outputs, reset to 0 and saturating at all-ones:
  - retired_cnt (32): +1 on every EXEC->FETCH transition and every MEM ack.
  - stall_cnt (32): +1 on every MEM cycle with dram_ack=0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then LDI R0,0x05; LDI R1,0x03; ADD R0,R1 -> dbg_reg(R0)=0x0008, Z=0, C=0; the ADD retires 3 cycles after its fetch.
- LDI R2,0xFF; LDI R3,0x01; SHL R2 eight times (DATA_W=8) -> R2=0x00, Z=1, C=1 on the final shift; then JC 0x40 -> pc_out=0x40.
- STORE R0,0x10 with ack delayed 5 cycles -> dram_req=1, dram_we=1, dram_addr=0x10, dram_out=0x0008, all held stable 5 cycles; req drops the edge after ack; stall_cnt=5 when the perf macro is defined.
- LOAD R1,0x20 with dram_in=0xBEEF, ack on the first MEM cycle -> R1=0xBEEF, flags unchanged, instruction total 4 cycles.
- Assert reset during MEM with ack pending -> next edge: dram_req=0, pc=0, R0..R3=0, state FETCH; a late ack causes no register write.
- pc at 0xFF executing NOP -> wraps to 0x00; HALT -> halted=1 and pc frozen for 20 cycles until reset.
